// File: rtl/gsu_bus_responder.sv
// rtl/gsu_bus_responder.sv - SNES bus cycle responder for the GSU gamepak ROM/RAM ports
//
// Accepts one CPU access at a time, decodes the 24-bit bus address into
// ROM / gamepak RAM / unmapped, and runs a req/ack handshake to the memory port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/addr/we/wdata (in)    access request, sampled when cpu_ready=1
//   cpu_ready/done/rdata/tmo      idle flag, completion pulse, read data, timeout pulse
//   rom_req/addr, rom_ack/rdata   ROM read handshake
//   ram_req/we/addr/wdata, ram_ack/rdata  RAM read/write handshake
module gsu_bus_responder #(
    parameter logic [20:0] ROM_MASK       = 21'h1fffff,
    parameter logic [16:0] RAM_MASK       = 17'h1ffff,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_tmo,
    output logic        rom_req,
    output logic [20:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_rdata,
    output logic        ram_req,
    output logic        ram_we,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ROM_RD  = 2'd1;
    localparam logic [1:0] S_RAM_ACC = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Abort is decided on the edge that ends the last allowed req cycle,
    // so req stays high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             rom_req_q, rom_req_d;
    logic [20:0]      rom_addr_q, rom_addr_d;
    logic             ram_req_q, ram_req_d;
    logic             ram_we_q, ram_we_d;
    logic [16:0]      ram_addr_q, ram_addr_d;
    logic [7:0]       ram_wdata_q, ram_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [7:0]       obus_q, obus_d;
    logic             tmo_q, tmo_d;

    // Address decode. Banks 00-3f map 32 kB per bank and ignore A15, so both
    // halves of each bank alias the same ROM page.
    logic        dec_rom_lo, dec_rom_hi, dec_ram;
    logic [20:0] rom_a;
    assign dec_rom_lo = (cpu_addr[23:22] == 2'b00);
    assign dec_rom_hi = (cpu_addr[23:21] == 3'b010);
    assign dec_ram    = (cpu_addr[23:21] == 3'b011);
    assign rom_a      = dec_rom_lo ? {cpu_addr[21:16], cpu_addr[14:0]} : cpu_addr[20:0];

    always_comb begin
        state_d     = state_q;
        rom_req_d   = rom_req_q;
        rom_addr_d  = rom_addr_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        obus_d      = obus_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if ((dec_rom_lo || dec_rom_hi) && !cpu_we) begin
                        state_d    = S_ROM_RD;
                        rom_req_d  = 1'b1;
                        rom_addr_d = rom_a & ROM_MASK;
                    end else if (dec_ram) begin
                        state_d     = S_RAM_ACC;
                        ram_req_d   = 1'b1;
                        ram_we_d    = cpu_we;
                        ram_addr_d  = cpu_addr[16:0] & RAM_MASK;
                        ram_wdata_d = cpu_wdata;
                    end else begin
                        // ROM write or unmapped: complete immediately with open bus.
                        state_d = S_DONE;
                        rdata_d = obus_q;
                    end
                end
            end
            S_ROM_RD: begin
                if (rom_ack) begin
                    state_d   = S_DONE;
                    rom_req_d = 1'b0;
                    rdata_d   = rom_rdata;
                    obus_d    = rom_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    rom_req_d = 1'b0;
                    tmo_d     = 1'b1;
                    rdata_d   = obus_q;
                    cnt_d     = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RAM_ACC: begin
                if (ram_ack) begin
                    state_d   = S_DONE;
                    ram_req_d = 1'b0;
                    rdata_d   = ram_we_q ? ram_wdata_q : ram_rdata;
                    obus_d    = ram_we_q ? ram_wdata_q : ram_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    ram_req_d = 1'b0;
                    tmo_d     = 1'b1;
                    rdata_d   = obus_q;
                    cnt_d     = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmo_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rom_req_q   <= 1'b0;
            rom_addr_q  <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            obus_q      <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_req_q   <= rom_req_d;
            rom_addr_q  <= rom_addr_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            obus_q      <= obus_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cpu_ready = (state_q == S_IDLE);
    assign cpu_done  = (state_q == S_DONE);
    assign cpu_tmo   = tmo_q;
    assign cpu_rdata = rdata_q;
    assign rom_req   = rom_req_q;
    assign rom_addr  = rom_addr_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_gsu_bus_responder.sv
// tb/tb_gsu_bus_responder.sv - directed self-checking bench for gsu_bus_responder
module tb_gsu_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [23:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready, cpu_done, cpu_tmo;
    logic [7:0]  cpu_rdata;
    logic        rom_req, rom_ack;
    logic [20:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic        ram_req, ram_we, ram_ack;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    gsu_bus_responder dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_tmo(cpu_tmo),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_rdata(rom_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [23:0] a, input logic we, input logic [7:0] wd);
        check("ready_before_accept", cpu_ready, 1);
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        tick();
        cpu_req   = 1'b0;
    endtask

    task automatic rom_read(input logic [23:0] a, input int delay, input logic [7:0] d,
                            input logic [20:0] exp_addr);
        access(a, 1'b0, 8'h00);
        check("rom_req_up", rom_req, 1);
        check("rom_addr", rom_addr, exp_addr);
        check("ram_req_idle", ram_req, 0);
        repeat (delay) tick();
        check("rom_no_done_yet", cpu_done, 0);
        rom_ack = 1'b1;
        rom_rdata = d;
        tick();
        rom_ack = 1'b0;
        check("rom_req_drop", rom_req, 0);
        check("rom_done", cpu_done, 1);
        check("rom_rdata", cpu_rdata, d);
        check("rom_tmo", cpu_tmo, 0);
        tick();
        check("rom_done_pulse", cpu_done, 0);
        check("rom_rdata_hold", cpu_rdata, d);
    endtask

    task automatic ram_access(input logic [23:0] a, input logic we, input logic [7:0] wd,
                              input int delay, input logic [7:0] rd,
                              input logic [16:0] exp_addr, input logic [7:0] exp_rdata);
        access(a, we, wd);
        check("ram_req_up", ram_req, 1);
        check("ram_we", ram_we, we);
        check("ram_addr", ram_addr, exp_addr);
        if (we) check("ram_wdata", ram_wdata, wd);
        check("rom_req_idle", rom_req, 0);
        repeat (delay) tick();
        check("ram_req_held", ram_req, 1);
        ram_ack = 1'b1;
        ram_rdata = rd;
        tick();
        ram_ack = 1'b0;
        check("ram_req_drop", ram_req, 0);
        check("ram_done", cpu_done, 1);
        check("ram_rdata", cpu_rdata, exp_rdata);
        check("ram_tmo", cpu_tmo, 0);
        tick();
        check("ram_done_pulse", cpu_done, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        rom_ack = 1'b0; rom_rdata = '0; ram_ack = 1'b0; ram_rdata = '0;
        tick(); tick();
        check("rst_ready", cpu_ready, 1);
        check("rst_done", cpu_done, 0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_tmo", cpu_tmo, 0);
        check("rst_reqs", {rom_req, ram_req, ram_we}, 0);
        check("rst_addrs", {rom_addr, ram_addr, ram_wdata}, 0);
        rst = 1'b0;
        tick();

        // Low ROM banks, ack one cycle after req; then immediate acks.
        rom_read(24'h008123, 1, 8'hA5, 21'h000123);
        rom_read(24'h018000, 0, 8'h11, 21'h008000);
        rom_read(24'h451234, 0, 8'h22, 21'h051234);
        rom_read(24'h3F7FFF, 0, 8'h33, 21'h1FFFFF);

        // RAM write then RAM read; writes return their own data.
        ram_access(24'h71BEEF, 1'b1, 8'h3C, 1, 8'h00, 17'h1BEEF, 8'h3C);
        ram_access(24'h601234, 1'b0, 8'h00, 0, 8'h5A, 17'h01234, 8'h5A);

        // Unmapped read: no memory request, 1-cycle latency, open-bus data.
        access(24'h800000, 1'b0, 8'h00);
        check("unm_done", cpu_done, 1);
        check("unm_rdata", cpu_rdata, 8'h5A);
        check("unm_no_req", {rom_req, ram_req}, 0);
        tick();
        check("unm_done_pulse", cpu_done, 0);

        // ROM write is discarded and completes like unmapped.
        access(24'h008000, 1'b1, 8'hEE);
        check("romwr_done", cpu_done, 1);
        check("romwr_rdata", cpu_rdata, 8'h5A);
        check("romwr_no_req", {rom_req, ram_req}, 0);
        tick();

        // Stray acks while idle are ignored.
        rom_ack = 1'b1; ram_ack = 1'b1;
        tick();
        rom_ack = 1'b0; ram_ack = 1'b0;
        check("stray_ack_done", cpu_done, 0);
        check("stray_ack_ready", cpu_ready, 1);

        // Ack in the 16th req cycle beats the timeout.
        ram_access(24'h600010, 1'b0, 8'h00, 15, 8'h77, 17'h00010, 8'h77);

        // No ack ever: req high 16 cycles, then done+tmo with open bus.
        access(24'h600000, 1'b0, 8'h00);
        n = 0;
        while (ram_req && n < 40) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", n, 16);
        check("tmo_done", cpu_done, 1);
        check("tmo_flag", cpu_tmo, 1);
        check("tmo_rdata", cpu_rdata, 8'h77);
        tick();
        check("tmo_flag_pulse", cpu_tmo, 0);
        check("tmo_ready", cpu_ready, 1);

        // Busy with cpu_req held and a different address; then reset mid-access.
        access(24'h008000, 1'b0, 8'h00);
        cpu_req = 1'b1; cpu_addr = 24'h610000;
        tick();
        check("busy_rom_req", rom_req, 1);
        check("busy_rom_addr", rom_addr, 21'h000000);
        check("busy_ignore_req", ram_req, 0);
        check("busy_not_ready", cpu_ready, 0);
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        check("mrst_reqs", {rom_req, ram_req}, 0);
        check("mrst_done", cpu_done, 0);
        check("mrst_ready", cpu_ready, 1);
        check("mrst_rdata", cpu_rdata, 8'h00);
        rst = 1'b0;
        tick(); tick();
        check("mrst_no_late_done", cpu_done, 0);
        check("mrst_idle_reqs", {rom_req, ram_req}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
